// File: rtl/handshake_arb_pkg.sv
// Shared definitions for the handshake shared-resource arbiters.
// Holds index-width sizing and the default constant payload.
package handshake_arb_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 30;
    localparam logic [DEFAULT_DATA_WIDTH-1:0] DEFAULT_CONST_VALUE =
        30'b110010000110100110110001110100;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first asserted request after last_grant,
// wrapping at NUM_REQ-1 back to 0.
module rr_priority_picker
    import handshake_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned IDX_WIDTH = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_last_grant,
    output logic [IDX_WIDTH-1:0] o_grant,
    output logic                 o_any_req
);

    logic [IDX_WIDTH-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        o_grant   = '0;
        o_any_req = 1'b0;
        w_cand    = '0;
        for (int unsigned k = NUM_REQ; k > 0; k--) begin
            w_cand = IDX_WIDTH'((32'(i_last_grant) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_grant   = w_cand;
                o_any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter sharing one handshake constant source among NUM_REQ
// ctrl requesters; each won token becomes one registered output token.
module handshake_constant_arbiter
    import handshake_arb_pkg::*;
#(
    parameter int unsigned           NUM_REQ     = 4,
    parameter int unsigned           DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] CONST_VALUE = DEFAULT_CONST_VALUE,
    parameter int unsigned           IDX_WIDTH   = idx_width(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    ins_valid,
    output logic [NUM_REQ-1:0]    ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic [IDX_WIDTH-1:0]  outs_index,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    logic                 r_valid;
    logic [IDX_WIDTH-1:0] r_index;
    logic [IDX_WIDTH-1:0] r_last_grant;

    logic                 w_load;
    logic [IDX_WIDTH-1:0] w_grant;
    logic                 w_any_req;

    rr_priority_picker #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_picker (
        .i_req        (ins_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_req    (w_any_req)
    );

    // The output slot can accept when empty or when drained this same cycle.
    assign w_load = !r_valid || outs_ready;

    // Gate with rst so no upstream token is consumed while reset is held.
    always_comb begin
        ins_ready = '0;
        if (rst && w_load && w_any_req) begin
            ins_ready[w_grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_index      <= '0;
            r_last_grant <= IDX_WIDTH'(NUM_REQ - 1);
        end else if (w_load) begin
            r_valid <= w_any_req;
            if (w_any_req) begin
                r_index      <= w_grant;
                r_last_grant <= w_grant;
            end
        end
    end

    assign outs       = CONST_VALUE;
    assign outs_index = r_index;
    assign outs_valid = r_valid;

endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// Self-checking bench: directed scenarios on a 4-requester instance and a
// randomized scoreboard run on a 3-requester instance.
module tb_handshake_constant_arbiter;

    localparam logic [29:0] C = 30'b110010000110100110110001110100;

    logic        clk;
    logic        rst;
    logic [3:0]  v4, rdy4_o;
    logic        r4;
    logic [29:0] outs4;
    logic [1:0]  idx4;
    logic        ov4;
    logic [2:0]  v3, rdy3_o;
    logic        r3;
    logic [29:0] outs3;
    logic [1:0]  idx3;
    logic        ov3;

    int checks;
    int failures;

    handshake_constant_arbiter dut4 (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (v4),
        .ins_ready  (rdy4_o),
        .outs       (outs4),
        .outs_index (idx4),
        .outs_valid (ov4),
        .outs_ready (r4)
    );

    handshake_constant_arbiter #(.NUM_REQ(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (v3),
        .ins_ready  (rdy3_o),
        .outs       (outs3),
        .outs_index (idx3),
        .outs_valid (ov3),
        .outs_ready (r3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference rule: first valid requester after last, wrapping at n.
    function automatic int mgrant(input logic [3:0] v, input int last, input int n);
        for (int off = 1; off <= n; off++) begin
            int idx;
            idx = (last + off) % n;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst = 1'b0; v4 = 4'b1111; r4 = 1'b1; v3 = '0; r3 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ov4); end
        checks++; if (idx4 !== 2'd0) begin failures++; $display("FAIL rst_index got=%0d exp=0", idx4); end
        checks++; if (outs4 !== C) begin failures++; $display("FAIL rst_outs got=%h exp=%h", outs4, C); end
        checks++; if (rdy4_o !== 4'b0000) begin failures++; $display("FAIL rst_ready got=%b exp=0000", rdy4_o); end
        @(negedge clk);
        v4 = 4'b0000; rst = 1'b1;
        #1;
        checks++; if (rdy4_o !== 4'b0000) begin failures++; $display("FAIL idle_ready got=%b exp=0000", rdy4_o); end
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL idle_valid got=%b exp=0", ov4); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        v4 = 4'b1111; r4 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            e = 4'b0001 << (k % 4);
            #1;
            checks++; if (rdy4_o !== e) begin failures++; $display("FAIL rr_ready k=%0d got=%b exp=%b", k, rdy4_o, e); end
            @(posedge clk); #1;
            checks++;
            if (ov4 !== 1'b1 || idx4 !== 2'(k % 4)) begin
                failures++; $display("FAIL rr_out k=%0d got=%b/%0d exp=1/%0d", k, ov4, idx4, k % 4);
            end
            @(negedge clk);
        end
        v4 = 4'b0000;
        #1;
        checks++; if (rdy4_o !== 4'b0000) begin failures++; $display("FAIL rr_idle_ready got=%b exp=0000", rdy4_o); end
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b exp=0", ov4); end
        @(negedge clk);
    endtask

    task automatic test_single();
        v4 = 4'b0100; r4 = 1'b1;
        #1;
        checks++; if (rdy4_o !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", rdy4_o); end
        @(posedge clk); #1;
        checks++;
        if (ov4 !== 1'b1 || idx4 !== 2'd2 || outs4 !== C) begin
            failures++; $display("FAIL single_out got=%b/%0d/%h exp=1/2/%h", ov4, idx4, outs4, C);
        end
        @(negedge clk);
        v4 = 4'b0000;
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", ov4); end
        @(negedge clk);
    endtask

    task automatic test_stall();
        // last grant is 2 here, so 1011 picks 3 first.
        v4 = 4'b1011; r4 = 1'b1;
        #1;
        checks++; if (rdy4_o !== 4'b1000) begin failures++; $display("FAIL stall_first_ready got=%b exp=1000", rdy4_o); end
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b1 || idx4 !== 2'd3) begin failures++; $display("FAIL stall_first got=%b/%0d exp=1/3", ov4, idx4); end
        @(negedge clk);
        r4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (rdy4_o !== 4'b0000) begin failures++; $display("FAIL stall_ready k=%0d got=%b exp=0000", k, rdy4_o); end
            @(posedge clk); #1;
            checks++;
            if (ov4 !== 1'b1 || idx4 !== 2'd3) begin
                failures++; $display("FAIL stall_hold k=%0d got=%b/%0d exp=1/3", k, ov4, idx4);
            end
            @(negedge clk);
        end
        r4 = 1'b1;
        #1;
        checks++; if (rdy4_o !== 4'b0001) begin failures++; $display("FAIL stall_resume_ready got=%b exp=0001", rdy4_o); end
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b1 || idx4 !== 2'd0) begin failures++; $display("FAIL stall_resume got=%b/%0d exp=1/0", ov4, idx4); end
        @(negedge clk);
        v4 = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [3:0] ev [3];
        logic [1:0] ei [3];
        logic [3:0] vv [3];
        vv[0] = 4'b1000; ev[0] = 4'b1000; ei[0] = 2'd3;
        vv[1] = 4'b1001; ev[1] = 4'b0001; ei[1] = 2'd0;
        vv[2] = 4'b1001; ev[2] = 4'b1000; ei[2] = 2'd3;
        r4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            v4 = vv[k];
            #1;
            checks++;
            if (rdy4_o !== ev[k] || $countones(rdy4_o) > 1) begin
                failures++; $display("FAIL wrap_ready k=%0d got=%b exp=%b", k, rdy4_o, ev[k]);
            end
            @(posedge clk); #1;
            checks++; if (ov4 !== 1'b1 || idx4 !== ei[k]) begin failures++; $display("FAIL wrap_out k=%0d got=%b/%0d exp=1/%0d", k, ov4, idx4, ei[k]); end
            @(negedge clk);
        end
        v4 = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        v4 = 4'b0010; r4 = 1'b0;
        @(posedge clk); #1;
        checks++; if (ov4 !== 1'b1 || idx4 !== 2'd1) begin failures++; $display("FAIL async_pre got=%b/%0d exp=1/1", ov4, idx4); end
        #2 rst = 1'b0;
        #1;
        checks++; if (ov4 !== 1'b0 || idx4 !== 2'd0) begin failures++; $display("FAIL async_drop got=%b/%0d exp=0/0", ov4, idx4); end
        checks++; if (rdy4_o !== 4'b0000) begin failures++; $display("FAIL async_ready got=%b exp=0000", rdy4_o); end
        @(negedge clk);
        rst = 1'b1; v4 = 4'b1111; r4 = 1'b1;
        #1;
        checks++; if (rdy4_o !== 4'b0001) begin failures++; $display("FAIL async_prio got=%b exp=0001", rdy4_o); end
        @(posedge clk); #1;
        checks++; if (idx4 !== 2'd0) begin failures++; $display("FAIL async_first got=%0d exp=0", idx4); end
        @(negedge clk);
        v4 = 4'b0000;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    // Random-run model state for the 3-requester instance.
    int         m_valid, m_idx, m_last;
    logic [2:0] pend;
    int         wcnt     [3];
    int         accepted [3];
    int         dut_out  [3];

    task automatic rand_cycle(input bit gen);
        logic       rdy, load;
        logic [2:0] e;
        int         g;
        rdy = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (gen) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1; wcnt[i] = 0;
                end
            end
        end
        v3 = pend; r3 = rdy;
        #1;
        load = (m_valid == 0) || rdy;
        g = mgrant({1'b0, pend}, m_last, 3);
        e = (load && g >= 0) ? 3'(1 << g) : 3'b000;
        checks++; if (rdy3_o !== e) begin failures++; $display("FAIL rnd_ready got=%b exp=%b", rdy3_o, e); end
        if (ov3 && rdy) begin
            checks++;
            if (idx3 >= 2'd3) begin failures++; $display("FAIL rnd_index got=%0d exp=<3", idx3); end
            else dut_out[idx3]++;
        end
        @(posedge clk);
        if (load) begin
            if (g >= 0) begin
                for (int i = 0; i < 3; i++) if (pend[i]) wcnt[i]++;
                checks++; if (wcnt[g] > 3) begin failures++; $display("FAIL rnd_wait req=%0d got=%0d exp=<=3", g, wcnt[g]); end
                accepted[g]++; pend[g] = 1'b0;
                m_valid = 1; m_idx = g; m_last = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        checks++;
        if (ov3 !== 1'(m_valid) || (m_valid != 0 && idx3 !== 2'(m_idx))) begin
            failures++; $display("FAIL rnd_out got=%b/%0d exp=%0d/%0d", ov3, idx3, m_valid, m_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_random3();
        v4 = '0; r4 = 1'b0; v3 = '0; r3 = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_valid = 0; m_idx = 0; m_last = 2; pend = '0;
        for (int i = 0; i < 3; i++) begin wcnt[i] = 0; accepted[i] = 0; dut_out[i] = 0; end
        for (int c = 0; c < 10000; c++) rand_cycle(1'b1);
        pend = '0;
        repeat (2) rand_cycle(1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dut_out[i] != accepted[i]) begin
                failures++; $display("FAIL rnd_count req=%0d got=%0d exp=%0d", i, dut_out[i], accepted[i]);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_wrap();
        test_async_reset();
        test_random3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
